seq_divider: RTL and testbench

Iterative radix-2 restoring divider for the multi-cycle datapath. It sits beside the ALU and replaces its single-cycle "a / b" path for DIV-class instructions. Operands come from the same A/B source registers that feed the ALU. Quotient goes to the ALU result path (low word) and remainder to the high-word path. The control FSM holds its execute state while busy is high and advances on done.

---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 139 +++++++++++++
 tb/tb_seq_divider.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Request/response bundle between the multi-cycle control path and the
// iterative divider: operands and start in, status and results out.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, fixed latency.
// Signed operation divides magnitudes and fixes signs in a final cycle.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  div_if
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               sgn_q, sgn_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic [WIDTH-1:0]   quo_out_q, quo_out_d;
    logic [WIDTH-1:0]   rem_out_q, rem_out_d;
    logic               dbz_q, dbz_d;

    logic               b_zero;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    assign b_zero  = (div_if.b == '0);
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (div_if.start) state_d = b_zero ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        div_if.busy = (state_q == S_CALC) || (state_q == S_FIX);
        div_if.done = (state_q == S_DONE);
    end

    // Datapath next values
    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        sgn_d     = sgn_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (div_if.start) begin
                    if (b_zero) begin
                        quo_out_d = '1;
                        rem_out_d = div_if.a;
                        dbz_d     = 1'b1;
                    end else begin
                        sgn_d = div_if.is_signed;
                        sa_d  = div_if.is_signed & div_if.a[WIDTH-1];
                        sb_d  = div_if.is_signed & div_if.b[WIDTH-1];
                        // Most-negative input wraps to itself, which reads
                        // correctly as the unsigned magnitude.
                        dvd_d = (div_if.is_signed && div_if.a[WIDTH-1]) ? -div_if.a : div_if.a;
                        dvs_d = (div_if.is_signed && div_if.b[WIDTH-1]) ? -div_if.b : div_if.b;
                        rem_d = '0;
                        cnt_d = CNT_W'(WIDTH);
                    end
                end
            end
            S_CALC: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                end
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q - CNT_W'(1);
            end
            S_FIX: begin
                quo_out_d = (sgn_q && (sa_q != sb_q)) ? -dvd_q : dvd_q;
                rem_out_d = (sgn_q && sa_q) ? -rem_q : rem_q;
                dbz_d     = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            sgn_q     <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            sgn_q     <= sgn_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    assign div_if.quotient    = quo_out_q;
    assign div_if.remainder   = rem_out_q;
    assign div_if.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: stimulus pushes expected results into a
// scoreboard; an independent monitor checks them whenever done pulses.
module tb_seq_divider;
    logic clk;
    logic reset;

    seq_divider_if #(.WIDTH(32)) dif ();

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .div_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (dif.done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no pending request");
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("[TB] done q=0x%08h r=0x%08h dbz=%0b (expect q=0x%08h r=0x%08h dbz=%0b)",
                         dif.quotient, dif.remainder, dif.div_by_zero, e.q, e.r, e.dbz);
                check("quotient",    dif.quotient,        e.q);
                check("remainder",   dif.remainder,       e.r);
                check("div_by_zero", 32'(dif.div_by_zero), 32'(e.dbz));
            end
        end
    end

    task automatic do_div(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input logic s, input logic [31:0] eq, input logic [31:0] er,
                          input logic edbz, input int exp_lat, input int exp_busy,
                          input bit disturb);
        int lat;
        int busy_n;
        bit got;
        lat = 0;
        busy_n = 0;
        got = 0;
        @(posedge clk); #1;
        dif.start = 1'b1;
        dif.a = av;
        dif.b = bv;
        dif.is_signed = s;
        sb.push_back('{q: eq, r: er, dbz: edbz});
        @(posedge clk); #1;
        dif.start = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (dif.busy) busy_n++;
            if (dif.done) got = 1;
            if (disturb && lat == 5) begin
                dif.start = 1'b1;
                dif.a = 32'd50;
                dif.b = 32'd5;
                dif.is_signed = ~s;
            end else if (disturb && lat == 6) begin
                dif.start = 1'b0;
            end
        end
        $display("[TB] %s a=0x%08h b=0x%08h signed=%0b latency=%0d busy_cycles=%0d",
                 name, av, bv, s, lat, busy_n);
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no done in 60 cycles expected done at %0d", name, exp_lat);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'(exp_lat));
            check({name, "_busy"},    32'(busy_n), 32'(exp_busy));
        end
    endtask

    initial begin
        int done_cnt;
        reset = 1'b1;
        dif.start = 1'b0;
        dif.is_signed = 1'b0;
        dif.a = '0;
        dif.b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(dif.busy), 32'd0);
        check("reset_done", 32'(dif.done), 32'd0);
        check("reset_q",    dif.quotient,  32'd0);
        check("reset_r",    dif.remainder, 32'd0);
        check("reset_dbz",  32'(dif.div_by_zero), 32'd0);

        do_div("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,        32'd2,          1'b0, 34, 33, 0);
        do_div("s-100_7",  32'hFFFFFF9C,   32'd7,          1'b1, 32'hFFFFFFF2,  32'hFFFFFFFE,   1'b0, 34, 33, 0);
        do_div("s100_-7",  32'd100,        32'hFFFFFFF9,   1'b1, 32'hFFFFFFF2,  32'd2,          1'b0, 34, 33, 0);
        do_div("u5_0",     32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,  32'd5,          1'b1, 1,  0,  0);
        do_div("s5_0",     32'd5,          32'd0,          1'b1, 32'hFFFFFFFF,  32'd5,          1'b1, 1,  0,  0);
        do_div("s_ovf",    32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,  32'd0,          1'b0, 34, 33, 0);
        do_div("u_min_max",32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,         32'h80000000,   1'b0, 34, 33, 0);
        do_div("u_disturb",32'd100,        32'd7,          1'b0, 32'd14,        32'd2,          1'b0, 34, 33, 1);
        do_div("b2b_50_5", 32'd50,         32'd5,          1'b0, 32'd10,        32'd0,          1'b0, 34, 33, 0);

        // Abort a long division with reset; no result may appear.
        @(posedge clk); #1;
        dif.start = 1'b1;
        dif.a = 32'hFFFFFFFF;
        dif.b = 32'd3;
        dif.is_signed = 1'b0;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(dif.busy), 32'd0);
        check("abort_done", 32'(dif.done), 32'd0);
        check("abort_q",    dif.quotient,  32'd0);
        check("abort_r",    dif.remainder, 32'd0);
        check("abort_dbz",  32'(dif.div_by_zero), 32'd0);
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.done) done_cnt++;
        end
        $display("[TB] abort after reset: done pulses in 40 cycles=%0d", done_cnt);
        check("abort_no_done", 32'(done_cnt), 32'd0);

        do_div("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 34, 33, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
